// File: rtl/mips_pkg.sv
// Shared MIPS core constants: datapath widths and the logic-unit / forwarding encodings.
package mips_pkg;

  localparam int unsigned n     = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned IMM_W = 16;

  localparam logic [1:0] LOG_AND = 2'b00;
  localparam logic [1:0] LOG_OR  = 2'b01;
  localparam logic [1:0] LOG_XOR = 2'b10;
  localparam logic [1:0] LOG_NOR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Forwarding comparator and mux for one EX-stage source operand.
module fwd_select
  import mips_pkg::*;
(
  input  logic [RA_W-1:0] i_src_addr,
  input  logic [n-1:0]    i_reg_data,
  input  logic            i_exmem_reg_write,
  input  logic [RA_W-1:0] i_exmem_rd,
  input  logic [n-1:0]    i_exmem_result,
  input  logic            i_memwb_reg_write,
  input  logic [RA_W-1:0] i_memwb_rd,
  input  logic [n-1:0]    i_memwb_result,
  output logic [n-1:0]    o_data,
  output logic [1:0]      o_fwd
);

  logic w_hit_mem;
  logic w_hit_wb;

  // r0 is hardwired, so a write to it must never shadow the register value.
  assign w_hit_mem = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_src_addr);
  assign w_hit_wb  = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_src_addr);

  always_comb begin
    o_fwd  = FWD_REG;
    o_data = i_reg_data;
    if (w_hit_mem) begin
      o_fwd  = FWD_MEM;
      o_data = i_exmem_result;
    end else if (w_hit_wb) begin
      o_fwd  = FWD_WB;
      o_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus forwarding-resolved operand selection for the logic unit.
module ex_operand_stage
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [n-1:0]     id_rs_data,
  input  logic [n-1:0]     id_rt_data,
  input  logic [IMM_W-1:0] id_imm,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic             id_alu_src,
  input  logic [1:0]       id_sel,
  input  logic             id_reg_write,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [n-1:0]     exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [n-1:0]     memwb_result,
  output logic [n-1:0]     A,
  output logic [n-1:0]     B,
  output logic [1:0]       sel,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic [RA_W-1:0]  ex_rd_addr,
  output logic [n-1:0]     ex_store_data,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic             r_valid;
  logic             r_reg_write;
  logic [RA_W-1:0]  r_rs_addr;
  logic [RA_W-1:0]  r_rt_addr;
  logic [RA_W-1:0]  r_rd_addr;
  logic [n-1:0]     r_rs_data;
  logic [n-1:0]     r_rt_data;
  logic [IMM_W-1:0] r_imm;
  logic             r_alu_src;
  logic [1:0]       r_sel;

  logic [n-1:0]     w_rs_fwd;
  logic [n-1:0]     w_rt_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_sel       <= LOG_AND;
    end else if (!stall) begin
      r_valid     <= id_valid;
      r_reg_write <= id_reg_write & id_valid;
      r_rs_addr   <= id_rs_addr;
      r_rt_addr   <= id_rt_addr;
      r_rd_addr   <= id_rd_addr;
      r_rs_data   <= id_rs_data;
      r_rt_data   <= id_rt_data;
      r_imm       <= id_imm;
      r_alu_src   <= id_alu_src;
      r_sel       <= id_sel;
    end
  end

  fwd_select u_fwd_rs (
    .i_src_addr        (r_rs_addr),
    .i_reg_data        (r_rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_rs_fwd),
    .o_fwd             (fwd_a)
  );

  fwd_select u_fwd_rt (
    .i_src_addr        (r_rt_addr),
    .i_reg_data        (r_rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_rt_fwd),
    .o_fwd             (fwd_b)
  );

  // Immediate is zero-extended, matching ANDI/ORI/XORI semantics.
  assign A             = w_rs_fwd;
  assign B             = r_alu_src ? {{(n-IMM_W){1'b0}}, r_imm} : w_rt_fwd;
  assign ex_store_data = w_rt_fwd;
  assign sel           = r_sel;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_reg_write;
  assign ex_rd_addr    = r_rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomised and directed bench for ex_operand_stage against a behavioural stage model.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid, id_alu_src, id_reg_write;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [1:0]  id_sel;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] A, B, ex_store_data;
  logic [1:0]  sel, fwd_a, fwd_b;
  logic        ex_valid, ex_reg_write;
  logic [4:0]  ex_rd_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Model of what the stage currently holds (one instruction's decoded fields).
  logic        m_valid, m_rw, m_alu_src;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rs_data, m_rt_data;
  logic [15:0] m_imm;
  logic [1:0]  m_sel;

  ex_operand_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rs_data      (id_rs_data),
    .id_rt_data      (id_rt_data),
    .id_imm          (id_imm),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_rd_addr      (id_rd_addr),
    .id_alu_src      (id_alu_src),
    .id_sel          (id_sel),
    .id_reg_write    (id_reg_write),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .A               (A),
    .B               (B),
    .sel             (sel),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_rd_addr      (ex_rd_addr),
    .ex_store_data   (ex_store_data),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_alu_src = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_sel = 0;
  endtask

  // Youngest producer wins; register 0 is never forwarded.
  task automatic model_operand(input logic [4:0] addr, input logic [31:0] data,
                               output logic [31:0] val, output logic [1:0] src);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == addr) begin
      val = exmem_result; src = 2;
    end else if (memwb_reg_write && memwb_rd != 0 && memwb_rd == addr) begin
      val = memwb_result; src = 1;
    end else begin
      val = data; src = 0;
    end
  endtask

  // Apply one rising edge to the model and the DUT, then return 1 time unit after it.
  task automatic cycle();
    if (!rst_n || flush) model_clear();
    else if (!stall) begin
      m_valid = id_valid; m_rw = id_reg_write && id_valid; m_alu_src = id_alu_src;
      m_rs = id_rs_addr; m_rt = id_rt_addr; m_rd = id_rd_addr;
      m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm; m_sel = id_sel;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_result = 0; memwb_result = 0;
  endtask

  task automatic load_instr(input logic [31:0] rs_d, input logic [31:0] rt_d,
                            input logic [4:0] rs_a, input logic [4:0] rt_a,
                            input logic [4:0] rd_a, input logic [1:0] s, input logic asrc);
    id_valid = 1; id_reg_write = 1; id_rs_data = rs_d; id_rt_data = rt_d;
    id_rs_addr = rs_a; id_rt_addr = rt_a; id_rd_addr = rd_a; id_sel = s; id_alu_src = asrc;
    stall = 0; flush = 0;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; id_valid = 0; id_reg_write = 0; id_alu_src = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_rs_addr = 0; id_rt_addr = 0;
    id_rd_addr = 0; id_sel = 0;
    no_fwd();
    model_clear();
    repeat (2) cycle();
    n_checks++;
    if ({ex_valid, ex_reg_write, sel, ex_rd_addr, fwd_a, fwd_b} !== 13'd0
        || A !== 0 || B !== 0 || ex_store_data !== 0) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%0b rw=%0b sel=%0b rd=%0d A=%0h B=%0h sd=%0h want all 0",
               ex_valid, ex_reg_write, sel, ex_rd_addr, A, B, ex_store_data);
    end
    #2 rst_n = 1;
  endtask

  task automatic test_load();
    load_instr(51, 486, 3, 4, 5, 2'b01, 0);
    n_checks++;
    if (A !== 51 || B !== 486 || sel !== 2'b01 || ex_valid !== 1 || ex_reg_write !== 1
        || ex_rd_addr !== 5) begin
      n_errors++;
      $display("FAIL load: got A=%0d B=%0d sel=%0b v=%0b rw=%0b rd=%0d want 51 486 01 1 1 5",
               A, B, sel, ex_valid, ex_reg_write, ex_rd_addr);
    end
    // Asynchronous reset mid-cycle must clear everything without waiting for an edge.
    #2 rst_n = 0;
    model_clear();
    #1;
    n_checks++;
    if (A !== 0 || B !== 0 || sel !== 0 || ex_valid !== 0 || ex_rd_addr !== 0) begin
      n_errors++;
      $display("FAIL async_reset: got A=%0d B=%0d sel=%0b v=%0b rd=%0d want all 0",
               A, B, sel, ex_valid, ex_rd_addr);
    end
    #1 rst_n = 1;
  endtask

  task automatic test_immediate();
    id_imm = 16'hFFFF;
    load_instr(12, 1553, 6, 7, 2, 2'b10, 1);
    n_checks++;
    if (B !== 32'h0000FFFF || ex_store_data !== 1553 || fwd_b !== 0) begin
      n_errors++;
      $display("FAIL immediate: got B=%0h sd=%0d fwd_b=%0b want 0000ffff 1553 00",
               B, ex_store_data, fwd_b);
    end
    // rt forwarding still reported and applied to store data while B uses the immediate.
    exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'hCAFE_0001;
    #1;
    n_checks++;
    if (fwd_b !== 2'b10 || B !== 32'h0000FFFF || ex_store_data !== 32'hCAFE_0001) begin
      n_errors++;
      $display("FAIL imm_fwd_b: got fwd_b=%0b B=%0h sd=%0h want 10 0000ffff cafe0001",
               fwd_b, B, ex_store_data);
    end
    no_fwd();
  endtask

  task automatic test_forwarding();
    load_instr(1, 2, 8, 9, 10, 2'b00, 0);
    exmem_reg_write = 1; exmem_rd = 8; exmem_result = 4152;
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 7;
    #1;
    n_checks++;
    if (A !== 4152 || fwd_a !== 2'b10) begin
      n_errors++;
      $display("FAIL fwd_mem_priority: got A=%0d fwd_a=%0b want 4152 10", A, fwd_a);
    end
    exmem_reg_write = 0;
    #1;
    n_checks++;
    if (A !== 7 || fwd_a !== 2'b01) begin
      n_errors++;
      $display("FAIL fwd_wb: got A=%0d fwd_a=%0b want 7 01", A, fwd_a);
    end
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
    load_instr(77, 2, 0, 9, 10, 2'b00, 0);
    n_checks++;
    if (A !== 77 || fwd_a !== 2'b00) begin
      n_errors++;
      $display("FAIL fwd_r0: got A=%0d fwd_a=%0b want 77 00", A, fwd_a);
    end
    no_fwd();
  endtask

  task automatic test_stall();
    logic [31:0] v;
    load_instr(51, 486, 3, 4, 5, 2'b01, 0);
    stall = 1; id_rs_data = 99; id_rt_data = 100;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (A !== 51 || B !== 486) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got A=%0d B=%0d want 51 486", i, A, B);
      end
    end
    exmem_reg_write = 1; exmem_rd = 3;
    for (int i = 0; i < 2; i++) begin
      v = $urandom;
      exmem_result = v;
      #1;
      n_checks++;
      if (A !== v) begin
        n_errors++;
        $display("FAIL stall_fwd_track[%0d]: got A=%0h want %0h", i, A, v);
      end
      cycle();
    end
    stall = 0;
    no_fwd();
  endtask

  task automatic test_flush_stall();
    load_instr(5, 6, 11, 12, 9, 2'b11, 0);
    flush = 1; stall = 1;
    cycle();
    n_checks++;
    if (ex_valid !== 0 || ex_reg_write !== 0 || sel !== 0 || ex_rd_addr !== 0 || A !== 0) begin
      n_errors++;
      $display("FAIL flush_over_stall: got v=%0b rw=%0b sel=%0b rd=%0d A=%0d want all 0",
               ex_valid, ex_reg_write, sel, ex_rd_addr, A);
    end
    flush = 0; stall = 0;
  endtask

  task automatic test_gated_write();
    id_valid = 0; id_reg_write = 1; id_rd_addr = 13;
    cycle();
    n_checks++;
    if (ex_reg_write !== 0 || ex_valid !== 0 || ex_rd_addr !== 13) begin
      n_errors++;
      $display("FAIL gated_write: got rw=%0b v=%0b rd=%0d want 0 0 13",
               ex_reg_write, ex_valid, ex_rd_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] ea, et, eb;
    logic [1:0]  fa, fb;
    for (int i = 0; i < 300; i++) begin
      id_valid = 1'($urandom); id_reg_write = 1'($urandom); id_alu_src = 1'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom); id_sel = 2'($urandom);
      stall = ($urandom_range(0, 3) == 0); flush = ($urandom_range(0, 7) == 0);
      cycle();
      exmem_reg_write = 1'($urandom); memwb_reg_write = 1'($urandom);
      exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom; memwb_result = $urandom;
      #1;
      model_operand(m_rs, m_rs_data, ea, fa);
      model_operand(m_rt, m_rt_data, et, fb);
      eb = m_alu_src ? 32'(m_imm) : et;
      n_checks++;
      if (A !== ea || B !== eb || ex_store_data !== et || fwd_a !== fa || fwd_b !== fb
          || sel !== m_sel || ex_valid !== m_valid || ex_reg_write !== m_rw
          || ex_rd_addr !== m_rd) begin
        n_errors++;
        $display("FAIL random[%0d]: got A=%0h B=%0h sd=%0h fa=%0b fb=%0b sel=%0b v=%0b rw=%0b rd=%0d want A=%0h B=%0h sd=%0h fa=%0b fb=%0b sel=%0b v=%0b rw=%0b rd=%0d",
                 i, A, B, ex_store_data, fwd_a, fwd_b, sel, ex_valid, ex_reg_write, ex_rd_addr,
                 ea, eb, et, fa, fb, m_sel, m_valid, m_rw, m_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_immediate();
    test_forwarding();
    test_stall();
    test_flush_stall();
    test_gated_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and execute-stage operand selector for the MIPS core.
- Directly upstream of the logic unit: drives its A, B and 2-bit sel inputs.
- Captures decoded operands and control from ID and holds them under stall or clears them under flush.
- Resolves EX/MEM and MEM/WB data hazards by forwarding, then presents final operands to the EX-stage units.

Parameters:
- n, 32, datapath width (A, B, register data, forwarded results).
- RA_W, 5, register address width.
- IMM_W, 16, immediate field width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold stage contents.
- flush  in  1  insert bubble.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data  in  n  register-file rs value.
- id_rt_data  in  n  register-file rt value.
- id_imm  in  IMM_W  immediate field.
- id_rs_addr  in  RA_W  rs index.
- id_rt_addr  in  RA_W  rt index.
- id_rd_addr  in  RA_W  destination index.
- id_alu_src  in  1  1 = B from immediate.
- id_sel  in  2  logic-unit op: 00 AND, 01 OR, 10 XOR, 11 NOR.
- id_reg_write  in  1  instruction writes the register file.
- exmem_reg_write  in  1  EX/MEM instruction writes.
- exmem_rd  in  RA_W  EX/MEM destination.
- exmem_result  in  n  EX/MEM result.
- memwb_reg_write  in  1  MEM/WB instruction writes.
- memwb_rd  in  RA_W  MEM/WB destination.
- memwb_result  in  n  MEM/WB writeback value.
- A  out  n  operand A to the logic unit.
- B  out  n  operand B to the logic unit.
- sel  out  2  op select to the logic unit.
- ex_valid  out  1  stage holds a real instruction.
- ex_reg_write  out  1  registered id_reg_write AND id_valid.
- ex_rd_addr  out  RA_W  registered destination.
- ex_store_data  out  n  forwarded rt value.
- fwd_a  out  2  forwarding select for A (00 reg, 01 MEM/WB, 10 EX/MEM).
- fwd_b  out  2  forwarding select for the rt path.

Behaviour:
- Reset:
  - rst_n low clears all stage registers asynchronously.
  - Registers cleared: valid, reg_write, rs/rt/rd addr, rs/rt data, imm, alu_src, sel.
  - Hence ex_valid = 0, ex_reg_write = 0, sel = 00, ex_rd_addr = 0, fwd_a = fwd_b = 00.
  - A, B and ex_store_data read 0 unless a forwarding source matches address 0. It cannot match, since r0 is never forwarded.
- Update priority at each clk rising edge: flush > stall > load.
  - flush: all stage registers cleared exactly as at reset. This applies even when stall is asserted in the same cycle.
  - stall (no flush): all registers hold their values. Forwarding still re-evaluates every cycle against the current EX/MEM and MEM/WB inputs.
  - load: all id_* fields are captured. ex_valid <= id_valid; ex_reg_write <= id_reg_write & id_valid.
- Latency: one cycle from ID inputs to the registered fields. A, B, fwd_* and ex_store_data are combinational from registered fields plus the forwarding inputs, so they settle in the same cycle.
- Forwarding, per source operand (rs shown; rt identical):
  - 10 if exmem_reg_write, exmem_rd != 0 and exmem_rd == ex_rs_addr.
  - else 01 if memwb_reg_write, memwb_rd != 0 and memwb_rd == ex_rs_addr.
  - else 00 (registered id_rs_data).
  - EX/MEM wins when both stages match (youngest value).
  - Register 0 never forwards; its value is the registered data.
- Operand outputs:
  - A = forwarded rs.
  - ex_store_data = forwarded rt.
  - B = alu_src ? zero-extended imm (upper n-IMM_W bits 0, as for ANDI/ORI/XORI) : forwarded rt.
  - fwd_b is reported even when alu_src = 1.
- sel passes through registered id_sel unchanged.
- Bubble (ex_valid = 0): operands are still computed. ex_reg_write = 0 guarantees there are no architectural side effects.

Decomposition:
- Shared package mips_pkg holds:
  - logic-op encodings LOG_AND = 2'b00, LOG_OR = 2'b01, LOG_XOR = 2'b10, LOG_NOR = 2'b11;
  - forwarding encodings FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - widths n, RA_W, IMM_W.
- One sub-module, fwd_select: pure comparator and mux for one operand, instantiated twice (rs, rt).
- The pipeline register stays in the top module.

Test Plan:
1. Reset/load: assert rst_n = 0 mid-cycle -> all outputs 0 immediately. Release, load id_rs_data = 51, id_rt_data = 486, sel = 01, alu_src = 0, id_valid = 1 -> next cycle A = 51, B = 486, sel = 01, ex_valid = 1.
2. Immediate: id_imm = 16'hFFFF, alu_src = 1, id_rt_data = 1553 -> B = 32'h0000FFFF, ex_store_data = 1553.
3. Forwarding priority: ex_rs_addr = 8, exmem_rd = 8, exmem_result = 4152, memwb_rd = 8, memwb_result = 7 (both write) -> A = 4152, fwd_a = 10. Drop exmem_reg_write -> A = 7, fwd_a = 01. Set all rd = 0 with ex_rs_addr = 0 -> fwd_a = 00.
4. Stall: stall = 1 while ID inputs change to 99/100 -> A/B hold 51/486 for 3 cycles. Change exmem_result during the stall with an rs match -> A tracks exmem_result.
5. Flush vs stall: flush = 1 and stall = 1 together, valid instruction in stage -> next cycle ex_valid = 0, ex_reg_write = 0, sel = 00, ex_rd_addr = 0.
6. Gated write: id_reg_write = 1, id_valid = 0 -> ex_reg_write = 0 after the load cycle.
